// File: rtl/spi_flash_responder.sv
// spi_flash_responder: oversampled SPI mode-0 slave emulating W25Q16BV read, JEDEC-ID and device-ID commands
module spi_flash_responder #(
    parameter int ADDR_W = 21,
    parameter logic [7:0] ID_MFR = 8'hEF,
    parameter logic [7:0] ID_TYPE = 8'h40,
    parameter logic [7:0] ID_CAP = 8'h15,
    parameter logic [7:0] ID_DEV = 8'h14
) (
    input logic clk,
    input logic reset,
    input logic SCK,
    input logic CSX,
    input logic SDI,
    output logic SDO,
    output logic [ADDR_W-1:0] mem_addr,
    output logic mem_rd,
    input logic [7:0] mem_data,
    output logic busy
);
    typedef enum logic [2:0] {WAIT, IDLE, CMD, ADDR, DATA, IGNORE} state_t;
    typedef enum logic [1:0] {MEM, DEV, JEDEC} src_t;
    state_t state, state_n;
    src_t src, src_n;
    logic [2:0] sck_s;
    logic [1:0] cs_s, sdi_s, primed, idx, idx_n;
    logic [4:0] cnt, cnt_n;
    logic [ADDR_W-2:0] sh, sh_n;
    logic [ADDR_W-1:0] sh_in, addr_n;
    logic [7:0] tx, tx_n, nxt, nxt_n;
    logic ld, ld_n, rd_n, rd_q, sdo_n, last, bc;
    logic cs_act, r, f;
    assign cs_act = ~cs_s[1];
    assign r = sck_s[1] & ~sck_s[2] & cs_act;
    assign f = ~sck_s[1] & sck_s[2] & cs_act;
    assign busy = !(state == IDLE || state == WAIT);
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_s <= '0;
            cs_s <= '1;
            sdi_s <= '0;
            primed <= '0;
            state <= WAIT;
            src <= MEM;
            cnt <= '0;
            sh <= '0;
            tx <= '0;
            nxt <= '0;
            idx <= '0;
            ld <= 1'b0;
            rd_q <= 1'b0;
            mem_rd <= 1'b0;
            mem_addr <= '0;
            SDO <= 1'b0;
        end else begin
            sck_s <= {sck_s[1:0], SCK};
            cs_s <= {cs_s[0], CSX};
            sdi_s <= {sdi_s[0], SDI};
            primed <= {primed[0], 1'b1};
            state <= state_n;
            src <= src_n;
            cnt <= cnt_n;
            sh <= sh_n;
            tx <= tx_n;
            nxt <= nxt_n;
            idx <= idx_n;
            ld <= ld_n;
            rd_q <= mem_rd;
            mem_rd <= rd_n;
            mem_addr <= addr_n;
            SDO <= sdo_n;
        end
    end
    always_comb begin
        state_n = state;
        src_n = src;
        cnt_n = cnt;
        sh_n = sh;
        tx_n = tx;
        ld_n = ld;
        idx_n = idx;
        rd_n = 1'b0;
        sh_in = {sh, sdi_s[1]};
        last = cnt == ((state == ADDR) ? 5'd23 : 5'd7);
        nxt_n = rd_q ? mem_data : nxt;
        addr_n = rd_q ? mem_addr + ADDR_W'(1) : mem_addr;
        case (state)
            WAIT: if (!cs_act && primed[1]) state_n = IDLE;
            IDLE: begin
                cnt_n = '0;
                tx_n = '0;
                ld_n = 1'b0;
                idx_n = '0;
                if (cs_act) state_n = CMD;
            end
            CMD, ADDR: if (r) begin
                sh_n = sh_in[ADDR_W-2:0];
                cnt_n = last ? 5'd0 : cnt + 5'd1;
                if (last && state == ADDR) begin
                    state_n = DATA;
                    if (src == MEM) addr_n = sh_in;
                end else if (last) begin
                    state_n = (sh_in[7:0] == 8'h03 || sh_in[7:0] == 8'hAB) ? ADDR :
                              (sh_in[7:0] == 8'h9F) ? DATA : IGNORE;
                    src_n = (sh_in[7:0] == 8'h03) ? MEM : (sh_in[7:0] == 8'hAB) ? DEV : JEDEC;
                end
            end
            DATA: begin
                if (r) cnt_n = last ? 5'd0 : cnt + 5'd1;
                if (f) begin
                    tx_n = ld ? nxt : {tx[6:0], 1'b0};
                    ld_n = 1'b0;
                end
            end
            default: ;
        endcase
        bc = r && last && (state == ADDR || state == DATA || (state == CMD && sh_in[7:0] == 8'h9F));
        if (bc) begin
            ld_n = 1'b1;
            rd_n = src_n == MEM;
            idx_n = (idx == 2'd3) ? idx : idx + 2'd1;
            if (src_n == DEV) nxt_n = ID_DEV;
            else if (src_n == JEDEC) nxt_n = (idx == 2'd0) ? ID_MFR : (idx == 2'd1) ? ID_TYPE :
                                             (idx == 2'd2) ? ID_CAP : 8'h00;
        end
        if (state != WAIT && !cs_act) state_n = IDLE;
        sdo_n = (state_n == DATA) && tx_n[7];
    end
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: table-driven SPI master with byte and mem_rd scoreboards
module tb_spi_flash_responder;
    localparam int H = 6;
    logic clk = 1'b0, reset = 1'b1, SCK = 1'b0, CSX = 1'b1, SDI = 1'b0;
    logic SDO, mem_rd, busy;
    logic [20:0] mem_addr;
    logic [7:0] mem_data = 8'h00;
    int n_chk = 0, n_fail = 0;
    logic [7:0] sbq[$];
    logic [20:0] rdq[$];
    typedef struct {
        logic [63:0] tx;
        int ntx;
        int nhdr;
        logic [31:0] exp;
        logic [20:0] a0;
        int nrd;
    } vec_t;
    vec_t vecs[5];

    spi_flash_responder dut (
        .clk(clk), .reset(reset), .SCK(SCK), .CSX(CSX), .SDI(SDI), .SDO(SDO),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (mem_rd) mem_data <= mem_addr[7:0] ^ 8'hA5;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) if (!reset && mem_rd) begin
        if (rdq.size() == 0) chk("unexpected_mem_rd", {11'h0, mem_addr}, 32'hFFFFFFFF);
        else chk("mem_rd_addr", {11'h0, mem_addr}, {11'h0, rdq.pop_front()});
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sbit(input logic b, input logic fin, output logic o);
        SDI = b;
        tick(H);
        SCK = 1'b1;
        if (fin) CSX = 1'b1;
        o = SDO;
        tick(H);
        SCK = 1'b0;
    endtask

    task automatic xbyte(input string name, input logic [7:0] d, input logic [7:0] e, input logic fin);
        logic [7:0] rx;
        logic b;
        sbq.push_back(e);
        for (int i = 7; i >= 0; i--) begin
            sbit(d[i], fin && i == 0, b);
            rx[i] = b;
        end
        chk(name, {24'h0, rx}, {24'h0, sbq.pop_front()});
    endtask

    task automatic run_vec(input vec_t v);
        for (int k = 0; k < v.nrd; k++) rdq.push_back(v.a0 + 21'(k));
        CSX = 1'b0;
        tick(H);
        for (int i = 0; i < v.ntx; i++)
            xbyte("rx_byte", v.tx[63-8*i -: 8], (i < v.nhdr) ? 8'h00 : v.exp[31-8*(i-v.nhdr) -: 8],
                  i == v.ntx - 1);
        tick(2 * H);
        chk("busy_after_cs", {31'h0, busy}, 0);
        chk("sdo_after_cs", {31'h0, SDO}, 0);
    endtask

    initial begin
        logic b;
        vecs[0] = '{{8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00}, 7, 4, 32'hB5B4B700, 21'h10, 3};
        vecs[1] = '{{8'h03, 8'h1F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00}, 6, 4, 32'h5AA50000, 21'h1FFFFF, 2};
        vecs[2] = '{{8'h9F, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 5, 1, 32'hEF401500, 21'h0, 0};
        vecs[3] = '{{8'hAB, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00}, 6, 4, 32'h14140000, 21'h0, 0};
        vecs[4] = '{{8'h03, 8'hE0, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00}, 5, 4, 32'hA0000000, 21'h5, 1};
        tick(4);
        reset = 1'b0;
        tick(1);
        chk("reset_sdo", {31'h0, SDO}, 0);
        chk("reset_mem_rd", {31'h0, mem_rd}, 0);
        chk("reset_mem_addr", {11'h0, mem_addr}, 0);
        chk("reset_busy", {31'h0, busy}, 0);
        tick(H);
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);
        // abort after 13 address bits
        CSX = 1'b0;
        tick(H);
        xbyte("abort_cmd", 8'h03, 8'h00, 1'b0);
        for (int i = 0; i < 13; i++) begin
            sbit(1'b1, 1'b0, b);
            chk("abort_addr_sdo", {31'h0, b}, 0);
        end
        CSX = 1'b1;
        tick(2 * H);
        chk("abort_busy", {31'h0, busy}, 0);
        chk("abort_sdo", {31'h0, SDO}, 0);
        run_vec(vecs[0]);
        // unknown command
        CSX = 1'b0;
        tick(H);
        xbyte("unk_cmd", 8'h05, 8'h00, 1'b0);
        xbyte("unk_data0", 8'hFF, 8'h00, 1'b0);
        xbyte("unk_data1", 8'hFF, 8'h00, 1'b0);
        chk("unk_busy", {31'h0, busy}, 1);
        CSX = 1'b1;
        tick(2 * H);
        chk("unk_busy_after", {31'h0, busy}, 0);
        // reset mid-read with CSX held low
        rdq.push_back(21'h10);
        rdq.push_back(21'h11);
        CSX = 1'b0;
        tick(H);
        xbyte("rst_cmd", 8'h03, 8'h00, 1'b0);
        xbyte("rst_a2", 8'h00, 8'h00, 1'b0);
        xbyte("rst_a1", 8'h00, 8'h00, 1'b0);
        xbyte("rst_a0", 8'h10, 8'h00, 1'b0);
        xbyte("rst_d0", 8'h00, 8'hB5, 1'b0);
        tick(H);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        chk("rst_mid_sdo", {31'h0, SDO}, 0);
        chk("rst_mid_addr", {11'h0, mem_addr}, 0);
        xbyte("rst_held0", 8'h03, 8'h00, 1'b0);
        xbyte("rst_held1", 8'hFF, 8'h00, 1'b0);
        chk("rst_held_busy", {31'h0, busy}, 0);
        CSX = 1'b1;
        tick(H);
        run_vec(vecs[0]);
        run_vec(vecs[2]);
        tick(H);
        chk("rd_queue_empty", rdq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
